// File: rtl/bundle_serializer.sv
// Frame serializer: shifts a captured WIDTH-bit word out LSB first, one bit per cycle.
// Optional even-parity trailer cycle is enabled by defining BUNDLE_SERIALIZER_PARITY_EN.
module bundle_serializer #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [IDX_W-1:0] index,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_first,
    output logic             out_last
);

`ifdef BUNDLE_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic [WIDTH-1:0] word_reg, word_next;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            index_reg <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            word_reg  <= word_next;
        end
    end

    // Outputs decode registered state only, so an asynchronous reset clears them at once.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        word_next  = word_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_first  = 1'b0;
        out_last   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready   = 1'b1;
                index_next = '0;
                if (in_valid) begin
                    word_next  = in_data;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = word_reg[index_reg];
                out_first = (index_reg == '0);
                if (index_reg != LAST_IDX) begin
                    index_next = index_reg + IDX_W'(1);
                end else begin
`ifdef BUNDLE_SERIALIZER_PARITY_EN
                    state_next = PAR;
`else
                    in_ready = 1'b1;
                    out_last = 1'b1;
                    if (in_valid) begin
                        // Back-to-back frame: index wraps naturally to 0.
                        word_next  = in_data;
                        index_next = index_reg + IDX_W'(1);
                    end else begin
                        state_next = IDLE;
                        index_next = '0;
                    end
`endif
                end
            end

`ifdef BUNDLE_SERIALIZER_PARITY_EN
            PAR: begin
                out_valid  = 1'b1;
                out_bit    = ^word_reg;
                out_last   = 1'b1;
                in_ready   = 1'b1;
                index_next = '0;
                if (in_valid) begin
                    word_next  = in_data;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    assign index = index_reg;

endmodule

// File: tb/tb_bundle_serializer.sv
// Scoreboard bench for bundle_serializer: WIDTH=4 and WIDTH=8 instances on one clock.
module tb_bundle_serializer;

`ifdef BUNDLE_SERIALIZER_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid4, in_ready4, out_valid4, out_bit4, out_first4, out_last4;
    logic [3:0] in_data4;
    logic [1:0] index4;
    logic       in_valid8, in_ready8, out_valid8, out_bit8, out_first8, out_last8;
    logic [7:0] in_data8;
    logic [2:0] index8;

    bundle_serializer #(.WIDTH(4)) dut4 (
        .clock(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .index(index4), .out_valid(out_valid4), .out_bit(out_bit4),
        .out_first(out_first4), .out_last(out_last4)
    );

    bundle_serializer #(.WIDTH(8)) dut8 (
        .clock(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .index(index8), .out_valid(out_valid8), .out_bit(out_bit8),
        .out_first(out_first8), .out_last(out_last8)
    );

    typedef struct {
        int b;
        int idx;
        int first;
        int last;
        int rdy;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   errors = 0;
    int   checks = 0;
    int   flen4  = 4 + PAR_EN;

    task automatic chk(input string tag, input integer obs, input integer expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            int lst;
            lst = ((i == 3) && (PAR_EN == 0)) ? 1 : 0;
            q4.push_back('{b: int'(w[i]), idx: i, first: (i == 0) ? 1 : 0, last: lst, rdy: lst});
        end
        if (PAR_EN != 0) q4.push_back('{b: int'(^w), idx: 3, first: 0, last: 1, rdy: 1});
    endtask

    task automatic push8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            int lst;
            lst = ((i == 7) && (PAR_EN == 0)) ? 1 : 0;
            q8.push_back('{b: int'(w[i]), idx: i, first: (i == 0) ? 1 : 0, last: lst, rdy: lst});
        end
        if (PAR_EN != 0) q8.push_back('{b: int'(^w), idx: 7, first: 0, last: 1, rdy: 1});
    endtask

    // Compare every emitted bit against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_valid", out_valid4, 0);
            end else begin
                e4 = q4.pop_front();
                chk("d4_bit",   out_bit4,   e4.b);
                chk("d4_index", index4,     e4.idx);
                chk("d4_first", out_first4, e4.first);
                chk("d4_last",  out_last4,  e4.last);
                chk("d4_ready", in_ready4,  e4.rdy);
            end
        end
        if (rst_n === 1'b1 && out_valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("d8_unexpected_valid", out_valid8, 0);
            end else begin
                e8 = q8.pop_front();
                chk("d8_bit",   out_bit8,   e8.b);
                chk("d8_index", index8,     e8.idx);
                chk("d8_first", out_first8, e8.first);
                chk("d8_last",  out_last8,  e8.last);
                chk("d8_ready", in_ready8,  e8.rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] w);
        int n;
        n = 0;
        while (in_ready4 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("d4_ready_before_send", in_ready4, 1);
        in_valid4 = 1'b1;
        in_data4  = w;
        push4(w);
        tick();
        in_valid4 = 1'b0;
        $display("d4 sent word %h", w);
    endtask

    task automatic wait_idle4(input string tag);
        int n;
        n = 0;
        while (out_valid4 !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle_valid"}, out_valid4, 0);
        chk({tag, "_idle_ready"}, in_ready4, 1);
        chk({tag, "_idle_index"}, index4, 0);
        chk({tag, "_idle_flags"}, {out_bit4, out_first4, out_last4}, 0);
        chk({tag, "_drained"}, q4.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  pushed;
        rst_n     = 1'b1;
        in_valid4 = 1'b0;
        in_data4  = '0;
        in_valid8 = 1'b0;
        in_data8  = '0;

        // Reset asserted before any clock edge must take effect immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready4", in_ready4, 1);
        chk("rst_valid4", out_valid4, 0);
        chk("rst_index4", index4, 0);
        chk("rst_flags4", {out_bit4, out_first4, out_last4}, 0);
        chk("rst_ready8", in_ready8, 1);
        chk("rst_valid8", out_valid8, 0);
        chk("rst_index8", index8, 0);
        #10 rst_n = 1'b1;
        tick();

        // Single word, then the parity-distinguishing word.
        send4(4'b1011);
        wait_idle4("single_1011");
        send4(4'b0011);
        wait_idle4("single_0011");

        // Back-to-back: in_valid held high, data changed after the first capture.
        in_valid4 = 1'b1;
        in_data4  = 4'hA;
        push4(4'hA);
        tick();
        in_data4 = 4'h5;
        pushed   = 1'b0;
        for (int c = 0; c < 2 * flen4; c++) begin
            chk("b2b_valid", out_valid4, 1);
            if (in_ready4 === 1'b1 && !pushed) begin
                push4(4'h5);
                pushed = 1'b1;
            end
            tick();
            if (pushed) in_valid4 = 1'b0;
        end
        $display("d4 back-to-back A then 5 done");
        wait_idle4("b2b");

        // in_data churns while a frame is in flight.
        send4(4'h6);
        n = 0;
        while (out_valid4 === 1'b1 && n < 20) begin
            in_data4 = 4'($urandom);
            tick();
            n++;
        end
        in_data4 = '0;
        $display("d4 toggle-data frame done");
        wait_idle4("toggle");

        // Asynchronous reset mid-frame at index 2.
        send4(4'h9);
        n = 0;
        while (!(out_valid4 === 1'b1 && index4 === 2'd2) && n < 20) begin
            tick();
            n++;
        end
        chk("reset_reach_idx2", index4, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid4, 0);
        chk("midrst_bit",   out_bit4, 0);
        chk("midrst_first", out_first4, 0);
        chk("midrst_last",  out_last4, 0);
        chk("midrst_index", index4, 0);
        chk("midrst_ready", in_ready4, 1);
        q4.delete();
        #3 rst_n = 1'b1;
        $display("d4 mid-frame reset applied");
        send4(4'hF);
        wait_idle4("after_reset");

        // Wider instance.
        in_valid8 = 1'b1;
        in_data8  = 8'h81;
        push8(8'h81);
        tick();
        in_valid8 = 1'b0;
        $display("d8 sent word 81");
        n = 0;
        while (out_valid8 !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("d8_idle_valid", out_valid8, 0);
        chk("d8_idle_ready", in_ready8, 1);
        chk("d8_idle_index", index8, 0);
        chk("d8_drained", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bundle_serializer.md
BUNDLE_SERIALIZER -- requirements
Module: bundle_serializer

Interface
REQ-001 Parameter SHALL be: WIDTH, default 4, word width in bits; power of two, at least 2.
REQ-002 Parameter SHALL be: IDX_W, default $clog2(WIDTH), width of the bit index.
REQ-003 Port SHALL be: clock  input  1  single clock; all state changes on posedge.
REQ-004 Port SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port SHALL be: in_valid  input  1  parallel word offered.
REQ-006 Port SHALL be: in_ready  output  1  serializer can accept a word this cycle.
REQ-007 Port SHALL be: in_data  input  WIDTH  parallel word.
REQ-008 Port SHALL be: index  output  IDX_W  bit position currently driven on out_bit.
REQ-009 Port SHALL be: out_valid  output  1  out_bit carries a frame bit this cycle.
REQ-010 Port SHALL be: out_bit  output  1  serial data bit.
REQ-011 Port SHALL be: out_first  output  1  first bit of frame (index 0).
REQ-012 Port SHALL be: out_last  output  1  final cycle of frame.

Function
REQ-013 States SHALL be IDLE, SHIFT and PAR; PAR SHALL exist only with PARITY_EN.
REQ-014 A word SHALL be accepted on any posedge where in_valid && in_ready; in_data SHALL be captured into an internal word register at that edge.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in the frame's last cycle, and 0 otherwise.
REQ-016 Acceptance SHALL go to SHIFT with index=0; the first bit SHALL appear in the cycle after the accepting edge (latency 1).
REQ-017 In SHIFT: out_valid=1 and out_bit=word[index]; index SHALL increment by 1 every cycle with no backpressure; bits go LSB first.
REQ-018 out_first SHALL be 1 only in SHIFT with index==0.
REQ-019 Without PARITY_EN, the SHIFT cycle with index==WIDTH-1 SHALL be the last cycle and SHALL assert out_last.
REQ-020 After the last cycle: if a word is accepted at that edge, go to SHIFT with index wrapping to 0 and no gap cycle; otherwise go to IDLE.
REQ-021 In IDLE: out_valid, out_bit, out_first and out_last SHALL be 0, and index SHALL hold 0.
REQ-022 in_data changes while in_ready=0 SHALL NOT affect the frame in flight.
REQ-023 index arithmetic SHALL be modulo 2^IDX_W; wrap from WIDTH-1 to 0 SHALL occur only on the back-to-back path.

Reset
REQ-024 On rst_n low, state SHALL become IDLE immediately, without waiting for a clock edge.
REQ-025 On rst_n low, index, out_valid, out_bit, out_first, out_last and the word register SHALL become 0, and in_ready SHALL become 1.
REQ-026 Reset mid-frame SHALL discard the partial word; no further bits of it SHALL be emitted.
REQ-027 The first accepting edge after rst_n deasserts SHALL behave as from IDLE.

Configuration
REQ-028 Macro BUNDLE_SERIALIZER_PARITY_EN SHALL control the parity feature.
REQ-029 With BUNDLE_SERIALIZER_PARITY_EN defined: after SHIFT index==WIDTH-1, enter PAR for one cycle.
REQ-030 In PAR: out_valid=1, out_bit=^word (even parity), out_first=0, out_last=1 and in_ready=1; index SHALL hold WIDTH-1.
REQ-031 With BUNDLE_SERIALIZER_PARITY_EN defined, the SHIFT cycle at index==WIDTH-1 SHALL have out_last=0 and in_ready=0.
REQ-032 With BUNDLE_SERIALIZER_PARITY_EN undefined: frame SHALL be exactly WIDTH cycles, and no PAR logic SHALL be present.

Verification
REQ-033 The bench SHALL cover: WIDTH=4, no parity, one word 4'b1011 -> out_bit 1,1,0,1 at index 0..3; out_first on cycle 1; out_last on cycle 4; then IDLE with in_ready=1.
REQ-034 The bench SHALL cover: parity enabled, 4'b1011 -> 1,1,0,1 then PAR bit 1 with out_last=1; 4'b0011 -> PAR bit 0.
REQ-035 The bench SHALL cover: in_valid held high with 4'hA then 4'h5 -> 0,1,0,1,1,0,1,0 contiguous, index wraps 3->0, out_valid never drops.
REQ-036 The bench SHALL cover: in_data toggled every cycle while in_ready=0 -> emitted bits match only the captured word.
REQ-037 The bench SHALL cover: rst_n pulsed low at index==2 -> outputs zero before the next edge, in_ready=1; the next word 4'hF emits 1,1,1,1 from index 0.
REQ-038 The bench SHALL cover: WIDTH=8, 8'h81 -> bits 1,0,0,0,0,0,0,1 over 8 cycles, index 0..7.
